// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback transmit path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StFetch  = 3'd2,
    StWaitTx = 3'd3,
    StGap    = 3'd4
  } send_state_e;

endpackage

// File: rtl/uart_send_ctrl.sv
// Transmit sequencer: drains data_length bytes from the byte FIFO into uart_tx,
// one byte per tx_done, with optional idle gap between bytes.
module uart_send_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES = 16'd0,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tx_en,
  input  logic [LEN_W-1:0]       data_length,
  input  logic                   fifo_empty,
  input  logic [UART_BYTE_W-1:0] fifo_rdata,
  output logic                   fifo_rd_en,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   send_go,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   send_done,
  output logic                   overrun
);

  send_state_e              state_q, state_d;
  logic [LEN_W-1:0]         remaining_q, remaining_d;
  logic [15:0]              gap_cnt_q, gap_cnt_d;
  logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                     send_go_q, send_go_d;
  logic                     busy_q, busy_d;
  logic                     send_done_q, send_done_d;
  logic                     overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    tx_data_d   = tx_data_q;
    send_go_d   = 1'b0;
    busy_d      = busy_q;
    send_done_d = 1'b0;
    overrun_d   = overrun_q;

    // A start request outside IDLE is dropped; the burst in flight continues.
    if (tx_en && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_en) begin
          if (data_length != '0) begin
            remaining_d = data_length;
            busy_d      = 1'b1;
            state_d     = StRead;
          end else begin
            send_done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (!fifo_empty) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        tx_data_d = fifo_rdata;
        send_go_d = 1'b1;
        state_d   = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          if (remaining_q <= LEN_W'(1)) begin
            busy_d      = 1'b0;
            send_done_d = 1'b1;
            state_d     = StIdle;
          end else if (GAP_CYCLES == 16'd0) begin
            state_d = StRead;
          end else begin
            // GAP lasts exactly GAP_CYCLES clocks including its first one.
            gap_cnt_d = GAP_CYCLES - 16'd1;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = StRead;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      gap_cnt_q   <= 16'd0;
      tx_data_q   <= '0;
      send_go_q   <= 1'b0;
      busy_q      <= 1'b0;
      send_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_data_q   <= tx_data_d;
      send_go_q   <= send_go_d;
      busy_q      <= busy_d;
      send_done_q <= send_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign fifo_rd_en = (state_q == StRead) && !fifo_empty;
  assign tx_data    = tx_data_q;
  assign send_go    = send_go_q;
  assign busy       = busy_q;
  assign send_done  = send_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_send_ctrl.sv
// Directed bench for uart_send_ctrl: FIFO and uart_tx modelled around one DUT,
// a second DUT with a 4-clock inter-byte gap driven by hand.
module tb_uart_send_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tx_en;
  logic [15:0] data_length;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        send_go;
  logic        tx_done;
  logic        busy;
  logic        send_done;
  logic        overrun;

  logic        g_tx_en;
  logic [15:0] g_len;
  logic        g_fifo_empty;
  logic [7:0]  g_fifo_rdata;
  logic        g_fifo_rd_en;
  logic [7:0]  g_tx_data;
  logic        g_send_go;
  logic        g_tx_done;
  logic        g_busy;
  logic        g_send_done;
  logic        g_overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_send_ctrl #(.GAP_CYCLES(16'd0), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .data_length(data_length),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .send_go(send_go), .tx_done(tx_done), .busy(busy),
    .send_done(send_done), .overrun(overrun)
  );

  uart_send_ctrl #(.GAP_CYCLES(16'd4), .LEN_W(16)) g_dut (
    .clk(clk), .reset_n(reset_n), .tx_en(g_tx_en), .data_length(g_len),
    .fifo_empty(g_fifo_empty), .fifo_rdata(g_fifo_rdata), .fifo_rd_en(g_fifo_rd_en),
    .tx_data(g_tx_data), .send_go(g_send_go), .tx_done(g_tx_done), .busy(g_busy),
    .send_done(g_send_done), .overrun(g_overrun)
  );

  // FIFO model: data valid one clock after the read strobe.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // uart_tx model: tx_done pulses 10 clocks after send_go.
  logic model_en = 1'b0;
  int   tx_cnt = 0;
  always @(posedge clk) begin
    if (!model_en) begin
      tx_cnt  <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= (tx_cnt == 1);
      if (send_go) tx_cnt <= 10;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
  end

  // Monitor: counts strobes, logs bytes, measures tx_done -> send_go latency.
  int n_go = 0;
  int n_rd = 0;
  int n_done = 0;
  int ncyc = 0;
  int done_cyc = 0;
  int last_lat = 0;
  logic [7:0] sent [$];
  always @(negedge clk) begin
    ncyc++;
    if (tx_done) done_cyc = ncyc;
    if (send_go) begin
      n_go++;
      sent.push_back(tx_data);
      last_lat = ncyc - done_cyc;
    end
    if (fifo_rd_en) n_rd++;
    if (send_done) n_done++;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic pulse_tx_en(input logic [15:0] len);
    @(negedge clk);
    tx_en       = 1'b1;
    data_length = len;
    @(negedge clk);
    tx_en = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input string name);
    int t = 0;
    while (n_done <= base_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (n_done <= base_done) begin
      failures++;
      $display("FAIL %s_timeout: send_done not seen within %0d cycles", name, t);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; tx_en = 1'b0; data_length = '0;
    g_tx_en = 1'b0; g_len = '0; g_fifo_empty = 1'b0; g_fifo_rdata = 8'h77; g_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (send_go !== 1'b0) begin failures++; $display("FAIL reset_send_go: got %b want 0", send_go); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if ({send_done, overrun, fifo_rd_en} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {send_done, overrun, fifo_rd_en}); end
    reset_n  = 1'b1;
    model_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bg = n_go, br = n_rd, bd = n_done, bs = sent.size();
    push(8'hA5); push(8'h5A); push(8'h3C);
    pulse_tx_en(16'd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_on: got %b want 1", busy); end
    wait_done(bd, "basic");
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_off: got %b want 0", busy); end
    repeat (20) @(negedge clk);
    checks++; if (n_go - bg !== 3) begin failures++; $display("FAIL basic_send_go_count: got %0d want 3", n_go - bg); end
    checks++; if (n_rd - br !== 3) begin failures++; $display("FAIL basic_rd_count: got %0d want 3", n_rd - br); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", n_done - bd); end
    checks++; if (sent[bs] !== 8'hA5) begin failures++; $display("FAIL basic_byte0: got %h want a5", sent[bs]); end
    checks++; if (sent[bs+1] !== 8'h5A) begin failures++; $display("FAIL basic_byte1: got %h want 5a", sent[bs+1]); end
    checks++; if (sent[bs+2] !== 8'h3C) begin failures++; $display("FAIL basic_byte2: got %h want 3c", sent[bs+2]); end
    checks++; if (last_lat !== 3) begin failures++; $display("FAIL basic_latency: got %0d want 3", last_lat); end
  endtask

  task automatic test_zero_length;
    int bg = n_go, br = n_rd, bd = n_done;
    pulse_tx_en(16'd0);
    checks++; if (send_done !== 1'b1) begin failures++; $display("FAIL zero_send_done: got %b want 1", send_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (send_done !== 1'b0) begin failures++; $display("FAIL zero_done_width: got %b want 0", send_done); end
    repeat (20) @(negedge clk);
    checks++; if ((n_go - bg) + (n_rd - br) !== 0) begin failures++; $display("FAIL zero_activity: got %0d want 0", (n_go - bg) + (n_rd - br)); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL zero_done_count: got %0d want 1", n_done - bd); end
  endtask

  task automatic test_underflow;
    int bg = n_go, br = n_rd, bd = n_done, bs = sent.size();
    int t = 0, rd_bad = 0, busy_bad = 0;
    push(8'h11);
    pulse_tx_en(16'd2);
    while (!tx_done && t < 200) begin @(negedge clk); t++; end
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL underflow_first_done: got %b want 1", tx_done); end
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd_en) rd_bad++;
      if (!busy) busy_bad++;
    end
    checks++; if (rd_bad !== 0) begin failures++; $display("FAIL underflow_stall_strobe: got %0d want 0", rd_bad); end
    checks++; if (busy_bad !== 0) begin failures++; $display("FAIL underflow_stall_busy: got %0d want 0", busy_bad); end
    checks++; if (n_go - bg !== 1) begin failures++; $display("FAIL underflow_stall_go: got %0d want 1", n_go - bg); end
    push(8'h22);
    wait_done(bd, "underflow");
    checks++; if (n_go - bg !== 2) begin failures++; $display("FAIL underflow_go_count: got %0d want 2", n_go - bg); end
    checks++; if (n_rd - br !== 2) begin failures++; $display("FAIL underflow_rd_count: got %0d want 2", n_rd - br); end
    checks++; if (sent[bs+1] !== 8'h22) begin failures++; $display("FAIL underflow_byte1: got %h want 22", sent[bs+1]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL underflow_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_overrun;
    int bg = n_go, bd = n_done, bs = sent.size();
    push(8'h31); push(8'h32);
    pulse_tx_en(16'd2);
    repeat (3) @(negedge clk);
    pulse_tx_en(16'd5);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b want 1", overrun); end
    wait_done(bd, "overrun");
    repeat (20) @(negedge clk);
    checks++; if (n_go - bg !== 2) begin failures++; $display("FAIL overrun_go_count: got %0d want 2", n_go - bg); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL overrun_done_count: got %0d want 1", n_done - bd); end
    checks++; if (sent[bs+1] !== 8'h32) begin failures++; $display("FAIL overrun_byte1: got %h want 32", sent[bs+1]); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst;
    int bg = n_go, bs, bd, t = 0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    pulse_tx_en(16'd4);
    while (n_go - bg < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    #2;
    reset_n  = 1'b0;
    model_en = 1'b0;
    #1;
    checks++; if ({busy, send_go, send_done, overrun, fifo_rd_en} !== 5'b0) begin failures++; $display("FAIL midreset_flags: got %b want 00000", {busy, send_go, send_done, overrun, fifo_rd_en}); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midreset_tx_data: got %h want 00", tx_data); end
    @(negedge clk);
    reset_n  = 1'b1;
    model_en = 1'b1;
    bs = sent.size();
    bd = n_done;
    pulse_tx_en(16'd1);
    wait_done(bd, "midreset");
    checks++; if (sent.size() - bs !== 1) begin failures++; $display("FAIL midreset_go_count: got %0d want 1", sent.size() - bs); end
    checks++; if (sent[bs] !== 8'h53) begin failures++; $display("FAIL midreset_byte: got %h want 53", sent[bs]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_gap;
    int t = 0, k;
    @(negedge clk);
    g_tx_en = 1'b1; g_len = 16'd2;
    @(negedge clk);
    g_tx_en = 1'b0;
    while (!g_send_go && t < 20) begin @(negedge clk); t++; end
    checks++; if (g_send_go !== 1'b1 || g_tx_data !== 8'h77) begin failures++; $display("FAIL gap_first_byte: got go=%b data=%h want go=1 data=77", g_send_go, g_tx_data); end
    repeat (3) @(negedge clk);
    g_tx_done = 1'b1;
    @(negedge clk);
    g_tx_done = 1'b0;
    k = 1;
    while (!g_send_go && k < 30) begin @(negedge clk); k++; end
    checks++; if (k !== 7) begin failures++; $display("FAIL gap_latency: got %0d want 7", k); end
    repeat (2) @(negedge clk);
    g_tx_done = 1'b1;
    @(negedge clk);
    g_tx_done = 1'b0;
    checks++; if (g_send_done !== 1'b1 || g_busy !== 1'b0) begin failures++; $display("FAIL gap_finish: got done=%b busy=%b want done=1 busy=0", g_send_done, g_busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_length;
    test_underflow;
    test_overrun;
    test_gap;
    test_reset_mid_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
